// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte per request, SSEL framing with a fixed deselect gap.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB-first on both MOSI and MISO (default is MSB-first).
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       start,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q;
  logic [7:0] divCnt_q;
  logic [2:0] bitCnt_q;
  logic [7:0] txShift_q;
  logic [7:0] rxShift_q;
  logic [7:0] rxData_q;
  logic       sck_q;
  logic       ssel_q;
  logic       busy_q;
  logic       rxValid_q;

  logic       halfDone_d;
  logic [7:0] txNext_d;
  logic [7:0] rxNext_d;
  logic       mosiBit_d;

  assign halfDone_d = (divCnt_q == DIV_LAST);

  // The bit on MOSI is always the outgoing end of the transmit shift register.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign txNext_d  = {1'b0, txShift_q[7:1]};
  assign rxNext_d  = {MISO, rxShift_q[7:1]};
  assign mosiBit_d = txShift_q[0];
`else
  assign txNext_d  = {txShift_q[6:0], 1'b0};
  assign rxNext_d  = {rxShift_q[6:0], MISO};
  assign mosiBit_d = txShift_q[7];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      divCnt_q  <= '0;
      bitCnt_q  <= '0;
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b1;
      busy_q    <= 1'b0;
      rxValid_q <= 1'b0;
    end else begin
      rxValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          divCnt_q <= '0;
          if (start) begin
            txShift_q <= tx_data;
            rxShift_q <= '0;
            bitCnt_q  <= '0;
            ssel_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (halfDone_d) begin
            divCnt_q <= '0;
            state_q  <= SHIFT;
          end else begin
            divCnt_q <= divCnt_q + 8'd1;
          end
        end
        // SHIFT opens with a low half-period, so the 8th falling edge lands on HOLD entry.
        SHIFT: begin
          if (halfDone_d) begin
            divCnt_q <= '0;
            if (!sck_q) begin
              sck_q     <= 1'b1;
              rxShift_q <= rxNext_d;
            end else begin
              sck_q    <= 1'b0;
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                state_q <= HOLD;
              end else begin
                txShift_q <= txNext_d;
              end
            end
          end else begin
            divCnt_q <= divCnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (halfDone_d) begin
            divCnt_q  <= '0;
            ssel_q    <= 1'b1;
            rxData_q  <= rxShift_q;
            rxValid_q <= 1'b1;
            state_q   <= GAP;
          end else begin
            divCnt_q <= divCnt_q + 8'd1;
          end
        end
        GAP: begin
          if (halfDone_d) begin
            divCnt_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            divCnt_q <= divCnt_q + 8'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          divCnt_q <= '0;
          sck_q    <= 1'b0;
          ssel_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;
  assign SCK      = sck_q;
  assign MOSI     = mosiBit_d;
  assign SSEL     = ssel_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked every cycle
// against a timeline model derived from the accept cycle, plus directed literal expectations.
module tb_spi_master;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic       clk = 1'b0;
  logic       rst     [2];
  logic       start   [2];
  logic [7:0] txData  [2];
  logic       busy    [2];
  logic [7:0] rxData  [2];
  logic       rxValid [2];
  logic       sck     [2];
  logic       mosi    [2];
  logic       miso    [2];
  logic       ssel    [2];
  logic       loop    [2];
  logic [7:0] reply   [2];
  logic       slaveBit[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(txData[0]), .start(start[0]), .busy(busy[0]),
    .rx_data(rxData[0]), .rx_valid(rxValid[0]), .SCK(sck[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .SSEL(ssel[0])
  );

  spi_master #(.CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(txData[1]), .start(start[1]), .busy(busy[1]),
    .rx_data(rxData[1]), .rx_valid(rxValid[1]), .SCK(sck[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .SSEL(ssel[1])
  );

  assign miso[0] = loop[0] ? mosi[0] : slaveBit[0];
  assign miso[1] = loop[1] ? mosi[1] : slaveBit[1];

  function automatic int divOf(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  // SCK is high on the even half-periods 2..16 counted from the first cycle after accept.
  function automatic logic expSck(input int k, input int d);
    int h;
    if (k < 1 || k > 18 * d) return 1'b0;
    h = (k - 1) / d;
    return (h >= 2 && h <= 16 && (h % 2) == 0);
  endfunction

  function automatic logic expMosi(input int k, input int d, input logic [7:0] tx);
    int h;
    int idx;
    h   = (k - 1) / d;
    idx = (h < 3) ? 0 : (h - 1) / 2;
    if (idx > 7) idx = 7;
`ifdef SPI_MASTER_LSB_FIRST_EN
    return tx[idx];
`else
    return tx[7 - idx];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: cycles elapsed since the accepting edge, and what the byte on the wire must be.
  int         mK     [2] = '{0, 0};
  logic [7:0] mTx    [2] = '{8'h00, 8'h00};
  logic [7:0] mReply [2] = '{8'h00, 8'h00};
  logic [7:0] mRx    [2] = '{8'h00, 8'h00};
  logic       live   [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i] === 1'b1) begin
        mK[i]   = 0;
        mRx[i]  = 8'h00;
        live[i] = 1'b1;
      end else if (mK[i] == 0) begin
        if (start[i] === 1'b1) begin
          mK[i]     = 1;
          mTx[i]    = txData[i];
          mReply[i] = loop[i] ? txData[i] : reply[i];
        end
      end else if (mK[i] == 19 * divOf(i)) begin
        mK[i] = 0;
      end else begin
        mK[i]++;
        if (mK[i] == 18 * divOf(i) + 1) mRx[i] = mReply[i];
      end
    end
  end

  // Mode-0 slave: presents its first bit at select, advances after each SCK fall.
  int   bitPtr   [2] = '{0, 0};
  logic slvPrevSck[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ssel[i] !== 1'b0) bitPtr[i] = 0;
      else if (slvPrevSck[i] && sck[i] === 1'b0 && bitPtr[i] < 7) bitPtr[i]++;
      slvPrevSck[i] = (sck[i] === 1'b1);
`ifdef SPI_MASTER_LSB_FIRST_EN
      slaveBit[i] = reply[i][bitPtr[i]];
`else
      slaveBit[i] = reply[i][7 - bitPtr[i]];
`endif
    end
  end

  int          rises     [2] = '{0, 0};
  int          edges     [2] = '{0, 0};
  int          sselLow   [2] = '{0, 0};
  int          rxValids  [2] = '{0, 0};
  int          highRun   [2] = '{0, 0};
  int          lastHighRun[2] = '{0, 0};
  int          mosiHighChg[2] = '{0, 0};
  logic [7:0]  mosiCap   [2] = '{8'h00, 8'h00};
  logic [15:0] rxLog     [2] = '{16'h0, 16'h0};
  logic        mPrevSck  [2] = '{1'b0, 1'b0};
  logic        mPrevSsel [2] = '{1'b1, 1'b1};
  logic        mPrevMosi [2] = '{1'b0, 1'b0};

  // Compare every output of both instances against the model on each falling clock edge.
  always @(negedge clk) begin : monitor
    int k;
    int d;
    logic active;
    for (int i = 0; i < 2; i++) begin
      if (live[i]) begin
        k      = mK[i];
        d      = divOf(i);
        active = (k >= 1 && k <= 18 * d);
        checkOutput($sformatf("busy[%0d]", i), 8'(busy[i]), 8'(k != 0));
        checkOutput($sformatf("ssel[%0d]", i), 8'(ssel[i]), 8'(!active));
        checkOutput($sformatf("sck[%0d]", i), 8'(sck[i]), 8'(expSck(k, d)));
        checkOutput($sformatf("rxValid[%0d]", i), 8'(rxValid[i]), 8'(k == 18 * d + 1));
        checkOutput($sformatf("rxData[%0d]", i), rxData[i], mRx[i]);
        if (active) checkOutput($sformatf("mosi[%0d]", i), 8'(mosi[i]), 8'(expMosi(k, d, mTx[i])));
      end
      if (sck[i] === 1'b1 && !mPrevSck[i]) begin
        rises[i]++;
        mosiCap[i] = {mosiCap[i][6:0], mosi[i]};
      end
      if ((sck[i] === 1'b1) != mPrevSck[i]) edges[i]++;
      if (ssel[i] === 1'b0) begin
        sselLow[i]++;
        if (mPrevSsel[i]) lastHighRun[i] = highRun[i];
        highRun[i] = 0;
      end else begin
        highRun[i]++;
      end
      if (rxValid[i] === 1'b1) begin
        rxValids[i]++;
        rxLog[i] = {rxLog[i][7:0], rxData[i]};
      end
      if (mosi[i] !== mPrevMosi[i] && sck[i] === 1'b1) mosiHighChg[i]++;
      mPrevSck[i]  = (sck[i] === 1'b1);
      mPrevSsel[i] = (ssel[i] !== 1'b0);
      mPrevMosi[i] = mosi[i];
    end
  end

  task automatic applyStimulus(input int i, input logic [7:0] data);
    txData[i] = data;
    start[i]  = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic waitIdle(input int i);
    int n = 0;
    while (busy[i] !== 1'b0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy[i] !== 1'b0) checkOutput("idleTimeout", 8'(busy[i]), 8'h00);
  endtask

  task automatic waitEdges(input int i, input int base, input int count, input logic useRises);
    int n = 0;
    while (((useRises ? rises[i] : edges[i]) - base) < count && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (((useRises ? rises[i] : edges[i]) - base) < count)
      checkOutput("edgeTimeout", 8'((useRises ? rises[i] : edges[i]) - base), 8'(count));
  endtask

  initial begin
    int bRise;
    int bEdge;
    int bLow;
    int bValid;
    int bChg;
    rst    = '{1'b1, 1'b1};
    start  = '{1'b0, 1'b0};
    txData = '{8'h00, 8'h00};
    loop   = '{1'b1, 1'b0};
    reply  = '{8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      checkOutput("resetSsel", 8'(ssel[i]), 8'h01);
      checkOutput("resetSck", 8'(sck[i]), 8'h00);
      checkOutput("resetMosi", 8'(mosi[i]), 8'h00);
      checkOutput("resetBusy", 8'(busy[i]), 8'h00);
      checkOutput("resetRxValid", 8'(rxValid[i]), 8'h00);
      checkOutput("resetRxData", rxData[i], 8'h00);
    end

    $display("[TB] reset wins over a simultaneous start");
    txData[0] = 8'hFF;
    start[0]  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstPriorityBusy", 8'(busy[0]), 8'h00);
    checkOutput("rstPrioritySsel", 8'(ssel[0]), 8'h01);
    start = '{1'b0, 1'b0};
    rst   = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] loopback 0xA5 at CLK_DIV=2");
    bRise = rises[0]; bLow = sselLow[0]; bValid = rxValids[0]; bChg = mosiHighChg[0];
    applyStimulus(0, 8'hA5);
    waitIdle(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("a5RxData", rxData[0], 8'hA5);
    checkOutput("a5RxValidCount", 8'(rxValids[0] - bValid), 8'd1);
    checkOutput("a5SselLowCycles", 8'(sselLow[0] - bLow), 8'd36);
    checkOutput("a5SckRises", 8'(rises[0] - bRise), 8'd8);
    checkOutput("a5MosiChangeHigh", 8'(mosiHighChg[0] - bChg), 8'd0);

    $display("[TB] slave replies 0x3C to 0xC3 at CLK_DIV=1");
    reply[1] = 8'h3C;
    bLow = sselLow[1]; bValid = rxValids[1]; bChg = mosiHighChg[1];
    applyStimulus(1, 8'hC3);
    waitIdle(1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("c3RxData", rxData[1], 8'h3C);
    checkOutput("c3MosiSequence", mosiCap[1], 8'hC3);
    checkOutput("c3MosiChangeHigh", 8'(mosiHighChg[1] - bChg), 8'd0);
    checkOutput("c3RxValidCount", 8'(rxValids[1] - bValid), 8'd1);
    checkOutput("c3SselLowCycles", 8'(sselLow[1] - bLow), 8'd18);

    $display("[TB] back-to-back 0x01 then 0x80");
    bValid = rxValids[0];
    applyStimulus(0, 8'h01);
    waitIdle(0);
    applyStimulus(0, 8'h80);
    waitIdle(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("b2bRxValidCount", 8'(rxValids[0] - bValid), 8'd2);
    checkOutput("b2bFirstByte", rxLog[0][15:8], 8'h01);
    checkOutput("b2bSecondByte", rxLog[0][7:0], 8'h80);
    checkOutput("b2bSselHighGap", 8'(lastHighRun[0]), 8'(DIV0 + 1));

    $display("[TB] start during a transfer is ignored");
    bEdge = edges[0]; bValid = rxValids[0];
    applyStimulus(0, 8'h3C);
    waitEdges(0, bEdge, 5, 1'b0);
    txData[0] = 8'hFF;
    start[0]  = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    waitIdle(0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ignRxValidCount", 8'(rxValids[0] - bValid), 8'd1);
    checkOutput("ignRxData", rxData[0], 8'h3C);
    checkOutput("ignMosiByte", mosiCap[0], 8'h3C);

    $display("[TB] reset at the 4th SCK rise");
    bRise = rises[0]; bValid = rxValids[0];
    applyStimulus(0, 8'h96);
    waitEdges(0, bRise, 4, 1'b1);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    checkOutput("abortSsel", 8'(ssel[0]), 8'h01);
    checkOutput("abortSck", 8'(sck[0]), 8'h00);
    checkOutput("abortBusy", 8'(busy[0]), 8'h00);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("abortNoRxValid", 8'(rxValids[0] - bValid), 8'd0);
    applyStimulus(0, 8'h5A);
    waitIdle(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("afterAbortRxData", rxData[0], 8'h5A);
    checkOutput("afterAbortRxValidCount", 8'(rxValids[0] - bValid), 8'd1);

    $display("[TB] loopback 0x01 bit order");
    applyStimulus(0, 8'h01);
    waitIdle(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("order01RxData", rxData[0], 8'h01);
`ifdef SPI_MASTER_LSB_FIRST_EN
    checkOutput("order01MosiSequence", mosiCap[0], 8'h80);
`else
    checkOutput("order01MosiSequence", mosiCap[0], 8'h01);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
